// File: rtl/register_file_pkg.sv
// Shared constants and types for the RV32I integer register file.
package register_file_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned NUM_REGS   = 32;
   localparam int unsigned REG_ADDR_W = 5;

   typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage : register_file_pkg

// File: rtl/regfile_read_port.sv
// One combinational read port: x0 returns zero, a same-cycle write is bypassed,
// otherwise the addressed array entry is returned.
module regfile_read_port
   import register_file_pkg::*;
#(
   parameter  int unsigned mem_width = XLEN,
   parameter  int unsigned mem_depth = NUM_REGS,
   localparam int unsigned AW        = $clog2(mem_depth)
) (
   input  logic [mem_width-1:0] regs_i [mem_depth],
   input  logic [AW-1:0]        sel_i,
   input  logic                 wr_en_i,
   input  logic [AW-1:0]        wr_addr_i,
   input  logic [mem_width-1:0] wr_data_i,
   output logic [mem_width-1:0] rd_data_c
);

   always_comb begin
      rd_data_c = regs_i[sel_i];
      if (sel_i == AW'(0)) begin
         rd_data_c = '0;
      end else if (wr_en_i && (sel_i == wr_addr_i)) begin
         rd_data_c = wr_data_i;
      end
   end

endmodule : regfile_read_port

// File: rtl/register_file.sv
// 2-read/1-write register file with x0 hard-wired to zero and write-through
// bypass so decode sees write-back data in the same cycle.
module register_file
   import register_file_pkg::*;
#(
   parameter  int unsigned mem_width = XLEN,
   parameter  int unsigned mem_depth = NUM_REGS,
   localparam int unsigned AW        = $clog2(mem_depth)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 we,
   input  logic [mem_width-1:0] Rin,
   input  logic [AW-1:0]        D_addr,
   input  logic [AW-1:0]        A_select,
   input  logic [AW-1:0]        B_select,
   output logic [mem_width-1:0] A_out,
   output logic [mem_width-1:0] B_out
);

   logic [mem_width-1:0] regs_q [mem_depth];
   logic [mem_width-1:0] regs_d [mem_depth];
   logic                 wr_en;

   // Reset wins over a coincident write, and also disables the bypass.
   assign wr_en = we && !reset;

   always_comb begin
      regs_d = regs_q;
      if (we && (D_addr != AW'(0))) begin
         regs_d[D_addr] = Rin;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   regfile_read_port #(
      .mem_width (mem_width),
      .mem_depth (mem_depth)
   ) u_port_a (
      .regs_i    (regs_q),
      .sel_i     (A_select),
      .wr_en_i   (wr_en),
      .wr_addr_i (D_addr),
      .wr_data_i (Rin),
      .rd_data_c (A_out)
   );

   regfile_read_port #(
      .mem_width (mem_width),
      .mem_depth (mem_depth)
   ) u_port_b (
      .regs_i    (regs_q),
      .sel_i     (B_select),
      .wr_en_i   (wr_en),
      .wr_addr_i (D_addr),
      .wr_data_i (Rin),
      .rd_data_c (B_out)
   );

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed test-plan scenarios plus
// randomized traffic against an array-based reference model.
module tb_register_file;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [31:0] Rin;
   logic [4:0]  D_addr;
   logic [4:0]  A_select;
   logic [4:0]  B_select;
   logic [31:0] A_out;
   logic [31:0] B_out;

   int errors = 0;
   int checks = 0;

   logic [31:0] model [32];
   bit          model_valid = 1'b0;

   always #5 clk = ~clk;

   register_file dut (
      .clk      (clk),
      .reset    (reset),
      .we       (we),
      .Rin      (Rin),
      .D_addr   (D_addr),
      .A_select (A_select),
      .B_select (B_select),
      .A_out    (A_out),
      .B_out    (B_out)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Architectural read value from the current inputs and stored state.
   function automatic logic [31:0] ref_read(input logic [4:0] sel);
      if (sel == 5'd0) return 32'd0;
      if (we && !reset && sel == D_addr) return Rin;
      return model[sel];
   endfunction

   // Drive one cycle's inputs away from the edge and check both ports.
   task automatic drive(input logic r, input logic w, input logic [4:0] d,
                        input logic [31:0] din, input logic [4:0] a, input logic [4:0] b);
      @(negedge clk);
      reset = r; we = w; D_addr = d; Rin = din; A_select = a; B_select = b;
      #1;
      if (model_valid) begin
         chk($sformatf("A[%0d]", a), A_out, ref_read(a));
         chk($sformatf("B[%0d]", b), B_out, ref_read(b));
      end
   endtask

   // Clock edge with model update.
   task automatic edge_upd();
      @(posedge clk);
      if (reset) begin
         foreach (model[i]) model[i] = 32'd0;
         model_valid = 1'b1;
      end else if (we && D_addr != 5'd0) begin
         model[D_addr] = Rin;
      end
   endtask

   task automatic cyc(input logic r, input logic w, input logic [4:0] d,
                      input logic [31:0] din, input logic [4:0] a, input logic [4:0] b);
      drive(r, w, d, din, a, b);
      edge_upd();
   endtask

   initial begin
      reset = 1'b1; we = 1'b0; Rin = '0; D_addr = '0; A_select = '0; B_select = '0;

      // Reset for two edges, then sweep both ports with reset still high.
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 32; i++) begin
         drive(1, 1, 5'(i), 32'hFFFF_FFFF, 5'(i), 5'(31 - i));
         chk("rst_sweep_a", A_out, 32'd0);
         chk("rst_sweep_b", B_out, 32'd0);
         edge_upd();
      end

      // Fill every register with index+1 (x0 write is ignored).
      for (int i = 0; i < 32; i++) cyc(0, 1, 5'(i), 32'(i + 1), 5'(i), 5'(31 - i));
      for (int k = 0; k < 32; k++) begin
         drive(0, 0, 5'd0, 32'd0, 5'(k), 5'(31 - k));
         chk("fill_a", A_out, (k == 0) ? 32'd0 : 32'(k + 1));
         chk("fill_b", B_out, (k == 31) ? 32'd0 : 32'(32 - k));
         edge_upd();
      end

      // Bypass: R[7]=0x11 then write 0xDEADBEEF with both ports on 7.
      cyc(0, 1, 5'd7, 32'h11, 5'd7, 5'd0);
      drive(0, 0, 5'd0, 32'd0, 5'd7, 5'd7);
      chk("byp_pre", A_out, 32'h11);
      edge_upd();
      drive(0, 1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd7);
      chk("byp_a", A_out, 32'hDEAD_BEEF);
      chk("byp_b", B_out, 32'hDEAD_BEEF);
      edge_upd();
      drive(0, 0, 5'd7, 32'h0, 5'd7, 5'd7);
      chk("byp_post_a", A_out, 32'hDEAD_BEEF);
      chk("byp_post_b", B_out, 32'hDEAD_BEEF);
      edge_upd();

      // x0 write is ignored before and after the edge.
      drive(0, 1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
      chk("x0_pre", A_out, 32'd0);
      edge_upd();
      drive(0, 0, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
      chk("x0_post", A_out, 32'd0);
      edge_upd();

      // we=0 must not disturb R[3] (holds 4 from the fill).
      for (int i = 0; i < 4; i++) cyc(0, 0, 5'd3, 32'h1234, 5'd3, 5'd3);
      drive(0, 0, 5'd3, 32'h1234, 5'd3, 5'd3);
      chk("hold_r3", A_out, 32'd4);
      edge_upd();

      // Reset beats a coincident write; everything reads zero afterwards.
      drive(1, 1, 5'd9, 32'hA5A5_A5A5, 5'd9, 5'd9);
      edge_upd();
      for (int k = 0; k < 32; k++) begin
         drive(0, 0, 5'd0, 32'd0, 5'(k), 5'(31 - k));
         chk("rstprio_a", A_out, 32'd0);
         chk("rstprio_b", B_out, 32'd0);
         edge_upd();
      end

      // Randomized traffic, reads often aimed at the write address.
      for (int n = 0; n < 400; n++) begin
         logic [4:0] d, a, b;
         d = 5'($urandom_range(0, 31));
         a = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
         b = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
         cyc(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), d, $urandom, a, b);
      end

      // Final readback of the whole file.
      for (int k = 0; k < 32; k++) cyc(0, 0, 5'd0, 32'd0, 5'(k), 5'(31 - k));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_register_file
